// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER pipeline constants and fetch FSM type
// Contents: PCSRC_* next-PC select codes, NOP_INSTR, fetch_state_t, word_align().
package otter_pkg;

  localparam logic [2:0] PCSRC_PC4    = 3'd0;
  localparam logic [2:0] PCSRC_JALR   = 3'd1;
  localparam logic [2:0] PCSRC_BRANCH = 3'd2;
  localparam logic [2:0] PCSRC_JAL    = 3'd3;
  localparam logic [2:0] PCSRC_MTVEC  = 3'd4;
  localparam logic [2:0] PCSRC_MEPC   = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RUN: nothing outstanding, WAIT: one request outstanding,
  // DROP: the outstanding request was squashed and its response is discarded.
  typedef enum logic [1:0] {RUN, WAIT, DROP} fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry pc/instr holding buffer for the fetch stage
// Ports: clk, rst_n (async, active-low); load/clear strobes (clear wins);
//        load_pc/load_instr entry data; valid/pc/instr buffered entry.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  import otter_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/otter_fetch_stage.sv
// rtl/otter_fetch_stage.sv - OTTER instruction-fetch stage with IF/ID register
// Ports: CLK, RST_N (async, active-low); PC_SOURCE/FLUSH/STALL and redirect targets
//        from execute/decode; IMEM_REQ/ADDR/GNT/RVALID/RDATA instruction memory;
//        IF_ID_VALID/PC/INSTR pipeline register outputs.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  PC_SOURCE,
  input  logic        FLUSH,
  input  logic        STALL,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_ID_VALID,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_INSTR
);
  import otter_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, req_pc, target;
  logic         hb_valid, hb_load, hb_clear;
  logic [31:0]  hb_pc, hb_instr;
  logic         resp_live, fire;

  // A response only counts while a live request is outstanding.
  assign resp_live = (state == WAIT) && IMEM_RVALID;

  // Response that cannot enter IF/ID because decode is holding a live instruction.
  assign hb_load = resp_live && IF_ID_VALID && STALL && !FLUSH;

  // Requests are also held off on the cycle the buffer is being filled, so a
  // second response can never arrive while both IF/ID and the buffer are full.
  assign IMEM_REQ  = RST_N && ((state == RUN) || resp_live) && !hb_valid && !hb_load && !FLUSH;
  assign IMEM_ADDR = word_align(pc);
  assign fire      = IMEM_REQ && IMEM_GNT;
  assign hb_clear  = FLUSH || (!STALL && hb_valid);

  always_comb begin
    target = pc + 32'd4;
    case (PC_SOURCE)
      PCSRC_JALR:   target = JALR_TGT;
      PCSRC_BRANCH: target = BRANCH_TGT;
      PCSRC_JAL:    target = JAL_TGT;
      PCSRC_MTVEC:  target = MTVEC;
      PCSRC_MEPC:   target = MEPC;
      default:      ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      // A same-cycle grant is already in flight at the memory, so it must be squashed too.
      if (IMEM_GNT || ((state != RUN) && !IMEM_RVALID)) state_nxt = DROP;
      else                                               state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (fire) state_nxt = WAIT;
        WAIT:    if (IMEM_RVALID) state_nxt = fire ? WAIT : RUN;
        DROP:    if (IMEM_RVALID) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= RUN;
      pc          <= RESET_PC;
      req_pc      <= '0;
      IF_ID_VALID <= 1'b0;
      IF_ID_PC    <= '0;
      IF_ID_INSTR <= NOP_INSTR;
    end else begin
      state <= state_nxt;

      if (FLUSH) begin
        pc <= word_align(target);
      end else if (fire) begin
        pc     <= pc + 32'd4;
        req_pc <= IMEM_ADDR;
      end

      if (FLUSH) begin
        IF_ID_VALID <= 1'b0;
        IF_ID_PC    <= '0;
        IF_ID_INSTR <= NOP_INSTR;
      end else if (resp_live && (!IF_ID_VALID || !STALL)) begin
        IF_ID_VALID <= 1'b1;
        IF_ID_PC    <= req_pc;
        IF_ID_INSTR <= IMEM_RDATA;
      end else if (!STALL) begin
        if (hb_valid) begin
          IF_ID_VALID <= 1'b1;
          IF_ID_PC    <= hb_pc;
          IF_ID_INSTR <= hb_instr;
        end else begin
          IF_ID_VALID <= 1'b0;
        end
      end
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (hb_load),
    .clear      (hb_clear),
    .load_pc    (req_pc),
    .load_instr (IMEM_RDATA),
    .valid      (hb_valid),
    .pc         (hb_pc),
    .instr      (hb_instr)
  );

endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb/tb_otter_fetch_stage.sv - self-checking bench for otter_fetch_stage
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [2:0]  PC_SOURCE;
  logic        FLUSH, STALL;
  logic [31:0] JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT, IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_ID_VALID;
  logic [31:0] IF_ID_PC, IF_ID_INSTR;

  int checks = 0;
  int passes = 0;

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_lat;

  logic        s_req, s_gnt, s_rvalid, s_flush, s_pend, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  always #5 CLK = ~CLK;

  otter_fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N), .PC_SOURCE(PC_SOURCE), .FLUSH(FLUSH), .STALL(STALL),
    .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IF_ID_VALID(IF_ID_VALID), .IF_ID_PC(IF_ID_PC), .IF_ID_INSTR(IF_ID_INSTR)
  );

  // Program image: every address holds a distinct word derived from it.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [2:0] src);
    case (src)
      3'd1:    return JALR_TGT;
      3'd2:    return BRANCH_TGT;
      3'd3:    return JAL_TGT;
      3'd4:    return MTVEC;
      3'd5:    return MEPC;
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_reset();
    RST_N = 1'b0; STALL = 1'b0; PC_SOURCE = 3'd0; FLUSH = 1'b0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0; pend = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One clock cycle from negedge to negedge with a single-outstanding memory model.
  task automatic drive(input bit st, input logic [2:0] src, input int lat, input bit gnt_en, input bit gnt_force);
    STALL = st; PC_SOURCE = src; FLUSH = (src != 3'd0) && !st;
    s_pend = pend;
    if (pend && pend_lat == 0) begin IMEM_RVALID = 1'b1; IMEM_RDATA = mem_word(pend_addr); end
    else begin IMEM_RVALID = 1'b0; IMEM_RDATA = $urandom; end
    #1;
    IMEM_GNT = gnt_force || (IMEM_REQ && gnt_en);
    #1;
    s_req = IMEM_REQ; s_gnt = IMEM_GNT; s_rvalid = IMEM_RVALID; s_flush = FLUSH;
    s_addr = IMEM_ADDR; s_valid = IF_ID_VALID; s_pc = IF_ID_PC; s_instr = IF_ID_INSTR;
    @(posedge CLK);
    if (IMEM_RVALID) pend = 1'b0;
    else if (pend && pend_lat > 0) pend_lat--;
    if (IMEM_GNT) begin pend = 1'b1; pend_addr = s_addr; pend_lat = lat; end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b1; STALL = 1'b0; PC_SOURCE = 3'd0; FLUSH = 1'b0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0; pend = 1'b0;
    JALR_TGT = '0; BRANCH_TGT = '0; JAL_TGT = '0; MTVEC = '0; MEPC = '0;
    #1 RST_N = 1'b0;
    #1;
    checks++; if (IF_ID_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", IF_ID_VALID); else passes++;
    checks++; if (IF_ID_PC !== 32'h0) $display("FAIL reset_pc: got %h want 0", IF_ID_PC); else passes++;
    checks++; if (IF_ID_INSTR !== NOP) $display("FAIL reset_instr: got %h want %h", IF_ID_INSTR, NOP); else passes++;
    @(negedge CLK);
    checks++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0) $display("FAIL reset_req: got req=%b addr=%h want req=0 addr=0", IMEM_REQ, IMEM_ADDR); else passes++;
    RST_N = 1'b1;
    #1;
    checks++; if (IMEM_REQ !== 1'b1) $display("FAIL reset_release_req: got %b want 1", IMEM_REQ); else passes++;
    @(negedge CLK);
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'(4*i))
        $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, s_req, s_addr, 32'(4*i));
      else passes++;
      if (i > 0) begin
        checks++;
        if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'(4*(i-1)) || IF_ID_INSTR !== mem_word(32'(4*(i-1))))
          $display("FAIL stream_ifid[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   i, IF_ID_VALID, IF_ID_PC, IF_ID_INSTR, 32'(4*(i-1)), mem_word(32'(4*(i-1))));
        else passes++;
      end
    end
  endtask

  // Continues from test_stream: IF/ID holds 0xC, response for 0x10 is due next cycle.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 0, 1'b1, 1'b0);
      checks++;
      if (s_req !== 1'b0 || IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'hC || IF_ID_INSTR !== mem_word(32'hC))
        $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h want req=0 v=1 pc=0000000c", i, s_req, IF_ID_VALID, IF_ID_PC);
      else passes++;
    end
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (s_req !== 1'b0 || IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h10 || IF_ID_INSTR !== mem_word(32'h10))
      $display("FAIL stall_drain: got req=%b v=%b pc=%h want req=0 v=1 pc=00000010", s_req, IF_ID_VALID, IF_ID_PC);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h14 || IF_ID_VALID !== 1'b0)
      $display("FAIL stall_resume: got req=%b addr=%h v=%b want req=1 addr=00000014 v=0", s_req, s_addr, IF_ID_VALID);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h14 || IF_ID_INSTR !== mem_word(32'h14))
      $display("FAIL stall_next: got v=%b pc=%h want v=1 pc=00000014", IF_ID_VALID, IF_ID_PC);
    else passes++;
  endtask

  task automatic test_flush_drop();
    do_reset();
    JAL_TGT = 32'h100;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 2, 1'b1, 1'b0);
    drive(1'b0, 3'd3, 0, 1'b0, 1'b0);
    checks++;
    if (IF_ID_VALID !== 1'b0 || IF_ID_INSTR !== NOP || IMEM_ADDR !== 32'h100)
      $display("FAIL flush_jal: got v=%b instr=%h addr=%h want v=0 instr=%h addr=00000100", IF_ID_VALID, IF_ID_INSTR, IMEM_ADDR, NOP);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++; if (s_req !== 1'b0) $display("FAIL flush_drop_req: got %b want 0", s_req); else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (s_rvalid !== 1'b1 || s_req !== 1'b0 || IF_ID_VALID !== 1'b0)
      $display("FAIL flush_late_resp: got rvalid=%b req=%b v=%b want rvalid=1 req=0 v=0", s_rvalid, s_req, IF_ID_VALID);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL flush_refetch: got req=%b addr=%h want req=1 addr=00000100", s_req, s_addr); else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h100 || IF_ID_INSTR !== mem_word(32'h100))
      $display("FAIL flush_target_ifid: got v=%b pc=%h want v=1 pc=00000100", IF_ID_VALID, IF_ID_PC);
    else passes++;
  endtask

  task automatic test_flush_gnt();
    do_reset();
    MTVEC = 32'h200;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd4, 0, 1'b0, 1'b1);
    checks++;
    if (s_rvalid !== 1'b1 || IF_ID_VALID !== 1'b0 || IMEM_ADDR !== 32'h200)
      $display("FAIL mtvec_flush: got rvalid=%b v=%b addr=%h want rvalid=1 v=0 addr=00000200", s_rvalid, IF_ID_VALID, IMEM_ADDR);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b0, 1'b0);
    checks++;
    if (s_rvalid !== 1'b1 || s_req !== 1'b0 || IF_ID_VALID !== 1'b0)
      $display("FAIL mtvec_squash_gnt: got rvalid=%b req=%b v=%b want rvalid=1 req=0 v=0", s_rvalid, s_req, IF_ID_VALID);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) $display("FAIL mtvec_refetch: got req=%b addr=%h want req=1 addr=00000200", s_req, s_addr); else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++; if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h200) $display("FAIL mtvec_ifid: got v=%b pc=%h want v=1 pc=00000200", IF_ID_VALID, IF_ID_PC); else passes++;
  endtask

  task automatic test_align_wrap();
    do_reset();
    JALR_TGT = 32'h103;
    drive(1'b0, 3'd1, 0, 1'b0, 1'b0);
    checks++; if (IMEM_ADDR !== 32'h100) $display("FAIL jalr_align: got %h want 00000100", IMEM_ADDR); else passes++;
    JALR_TGT = 32'hFFFF_FFFE;
    drive(1'b0, 3'd1, 0, 1'b0, 1'b0);
    checks++; if (IMEM_ADDR !== 32'hFFFF_FFFC) $display("FAIL jalr_top: got %h want fffffffc", IMEM_ADDR); else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (s_addr !== 32'hFFFF_FFFC || IMEM_ADDR !== 32'h0)
      $display("FAIL pc_wrap: got granted=%h next=%h want granted=fffffffc next=00000000", s_addr, IMEM_ADDR);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_INSTR !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap_ifid: got v=%b pc=%h want v=1 pc=fffffffc", IF_ID_VALID, IF_ID_PC);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 2, 1'b1, 1'b0);
    checks++; if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h4) $display("FAIL mid_pre: got v=%b pc=%h want v=1 pc=00000004", IF_ID_VALID, IF_ID_PC); else passes++;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (IF_ID_VALID !== 1'b0 || IF_ID_PC !== 32'h0 || IF_ID_INSTR !== NOP || IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0)
      $display("FAIL mid_async_clear: got v=%b pc=%h instr=%h req=%b addr=%h want v=0 pc=0 instr=%h req=0 addr=0",
               IF_ID_VALID, IF_ID_PC, IF_ID_INSTR, IMEM_REQ, IMEM_ADDR, NOP);
    else passes++;
    @(negedge CLK);
    RST_N = 1'b1;
    pend_lat = 0;
    drive(1'b0, 3'd0, 0, 1'b0, 1'b0);
    checks++;
    if (s_rvalid !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'h0 || IF_ID_VALID !== 1'b0)
      $display("FAIL mid_late_resp: got rvalid=%b req=%b addr=%h v=%b want rvalid=1 req=1 addr=0 v=0", s_rvalid, s_req, s_addr, IF_ID_VALID);
    else passes++;
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 0, 1'b1, 1'b0);
    checks++;
    if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h0 || IF_ID_INSTR !== mem_word(32'h0))
      $display("FAIL mid_restart: got v=%b pc=%h want v=1 pc=0", IF_ID_VALID, IF_ID_PC);
    else passes++;
  endtask

  // Scoreboard: decode must see the program in address order from the last redirect,
  // each word exactly once, regardless of stalls, memory latency and grant timing.
  task automatic test_random(input int n);
    logic [31:0] exp_addr, tgt;
    logic [2:0]  src;
    bit          st;
    int          consumed;
    do_reset();
    exp_addr = 32'h0;
    consumed = 0;
    for (int c = 0; c < n; c++) begin
      st = ($urandom_range(0, 3) == 0);
      if (st)                              src = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 15) == 0) src = 3'($urandom_range(1, 5));
      else                                 src = 3'd0;
      JALR_TGT = $urandom; BRANCH_TGT = $urandom; JAL_TGT = $urandom; MTVEC = $urandom; MEPC = $urandom;
      tgt = tgt_of(src);
      drive(st, src, $urandom_range(0, 2), ($urandom_range(0, 2) != 0), 1'b0);
      if (s_req && s_gnt) begin
        checks++;
        if (s_pend && !s_rvalid) $display("FAIL rnd_one_outstanding[%0d]: got second grant at %h want none", c, s_addr);
        else passes++;
      end
      if (s_flush) begin
        checks++;
        if (IF_ID_VALID !== 1'b0 || IMEM_ADDR !== (tgt & 32'hFFFF_FFFC))
          $display("FAIL rnd_flush[%0d]: got v=%b addr=%h want v=0 addr=%h", c, IF_ID_VALID, IMEM_ADDR, tgt & 32'hFFFF_FFFC);
        else passes++;
        exp_addr = tgt & 32'hFFFF_FFFC;
      end else if (s_valid && !st) begin
        checks++;
        if (s_pc !== exp_addr || s_instr !== mem_word(exp_addr))
          $display("FAIL rnd_stream[%0d]: got pc=%h instr=%h want pc=%h instr=%h", c, s_pc, s_instr, exp_addr, mem_word(exp_addr));
        else passes++;
        exp_addr = exp_addr + 32'd4;
        consumed++;
      end else if (s_valid && st) begin
        checks++;
        if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== s_pc || IF_ID_INSTR !== s_instr)
          $display("FAIL rnd_hold[%0d]: got v=%b pc=%h want v=1 pc=%h", c, IF_ID_VALID, IF_ID_PC, s_pc);
        else passes++;
      end
    end
    checks++;
    if (consumed < n / 8) $display("FAIL rnd_progress: got %0d instructions want at least %0d", consumed, n / 8);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_drop();
    test_flush_gnt();
    test_align_wrap();
    test_reset_mid();
    test_random(3000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
